rle_share_ctrl: RTL and testbench
=================================

Name: rle_share_ctrl

Overview:
- Time-shares one run-length encoder (5-bit data, 255-entry buffer, write_signal/read_signal control) between NUM_REQ independent stream sources.
- Round-robin grant per burst: fill the encoder buffer from one source, drain it fully downstream, then flush it.
- Flushing after each drain keeps runs from merging across sources.
- Sits between the source front-ends and the encoder; the encoder runs on the same data_clk.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8)
- DATA_W, 5, symbol width
- DEPTH, 255, encoder buffer capacity mirrored by the occupancy counter
- BURST_MAX, 8, maximum symbols accepted per grant
- STALL_MAX, 16, idle FILL cycles (granted source not valid) before the burst is closed
- ID_W, 2, width of the source id; equals clog2(NUM_REQ)

Ports:
- data_clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-source symbol valid
- req_data  in  NUM_REQ*DATA_W  per-source symbols; source i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  per-source end-of-packet marker, qualified by valid
- req_ready  out  NUM_REQ  one-hot accept to the granted source
- drain_ready  in  1  downstream can take one encoder read this cycle
- enc_data_in  out  DATA_W  symbol to encoder
- enc_data_in_valid  out  1  qualifies enc_data_in
- enc_write_signal  out  1  encoder write strobe
- enc_read_signal  out  1  encoder read strobe
- enc_reset  out  1  encoder flush
- active_id  out  ID_W  currently granted source
- busy  out  1  high when state is not IDLE

Behaviour:
- States: IDLE, FILL, DRAIN, FLUSH. Registers: state, grant, rr_ptr, occ (8 bit), beat_cnt, stall_cnt.
- Reset: state=IDLE, rr_ptr=0, grant=0, occ=0, counters=0. All outputs are 0 during and after reset, except enc_reset.
- enc_reset = reset OR (state==FLUSH). This is combinational.
- Reset mid-burst or mid-drain aborts immediately. The partial burst is discarded and no source sees ready.
- All other outputs are combinational decodes of registered state. No output depends combinationally on drain_ready except enc_read_signal.
- IDLE:
  - If any req_valid: grant = first set bit searching from rr_ptr upward with wrap; clear beat_cnt and stall_cnt; go to FILL next cycle.
  - This gives one cycle of arbitration latency.
  - Otherwise stay in IDLE.
- FILL:
  - req_ready[grant] = (occ < DEPTH).
  - Transfer occurs when req_valid[grant] and ready are both high. On transfer: enc_write_signal=1, enc_data_in_valid=1, enc_data_in=req_data[grant]; occ+1; beat_cnt+1; stall_cnt cleared.
  - No transfer: stall_cnt+1.
  - Go to DRAIN after the cycle in which any of these holds:
    - transfer with req_last;
    - beat_cnt reaches BURST_MAX;
    - occ reaches DEPTH;
    - stall_cnt reaches STALL_MAX.
  - If none of the exit conditions is met, stay in FILL.
- DRAIN:
  - enc_read_signal = drain_ready AND (occ != 0). Each read decrements occ.
  - Go to FLUSH in the cycle occ is 0. A burst closed by the stall timeout with zero beats passes straight through in one cycle.
- FLUSH: one cycle; enc_reset=1; rr_ptr = (grant+1) mod NUM_REQ; next state IDLE.
- Read and write strobes are never asserted in the same cycle.
- occ never exceeds DEPTH and never goes below 0.
- req_ready is asserted only in FILL, only to grant, and only when occ < DEPTH.
- Sources not granted are held off indefinitely until their turn. Worst-case wait is (NUM_REQ-1) full burst+drain+flush cycles.

Decomposition:
- Shared package holds the state enum (IDLE/FILL/DRAIN/FLUSH) and default constants for DATA_W and DEPTH, so they match the encoder.
- One sub-module, rr_pick: combinational rotate/priority-encode of req_valid from rr_ptr. Inputs: req_valid, rr_ptr. Outputs: grant index and any_valid.

Test Plan:
- Single source 0 sends 3 symbols (5,5,9) with last on the third, drain_ready=1:
  - 3 write strobes; occ reaches 3; then 3 read strobes;
  - one enc_reset pulse; rr_ptr=1; busy drops.
- All 4 sources valid continuously with no last:
  - grants in order 0,1,2,3,0;
  - each burst has exactly BURST_MAX=8 writes;
  - req_ready is never high on more than one bit.
- Source 2 granted, sends 1 symbol, then drops valid:
  - after 16 stall cycles, DRAIN issues 1 read, then FLUSH;
  - next grant search starts at 3.
- drain_ready held 0 for 10 cycles in DRAIN:
  - no read strobes;
  - occ holds;
  - reads resume the cycle drain_ready=1.
- Reset asserted mid-FILL after 4 beats:
  - next cycle state=IDLE, occ=0, all req_ready=0;
  - enc_reset high during reset;
  - rr_ptr=0.

Source files
------------

// File: rtl/rle_share_ctrl_pkg.sv
// Shared types and encoder-matching defaults for the RLE share controller.
package rle_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Must match the run-length encoder instance this controller feeds.
    localparam int ENC_DATA_W = 5;
    localparam int ENC_DEPTH  = 255;

endpackage

// File: rtl/rle_share_ctrl_rr_pick.sv
// Round-robin pick: first valid requester at or after rr_ptr_i, with wrap.
module rle_share_ctrl_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [ID_W-1:0]    grant_o,
    output logic               any_valid_o
);

    logic [ID_W:0] idx;

    // Walk from the farthest candidate back to rr_ptr so the nearest valid one wins.
    always_comb begin
        grant_o     = '0;
        any_valid_o = |req_valid_i;
        idx         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_i} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(NUM_REQ)) begin
                idx = idx - (ID_W + 1)'(NUM_REQ);
            end
            if (req_valid_i[idx[ID_W-1:0]]) begin
                grant_o = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rle_share_ctrl.sv
// Time-shares one RLE encoder between NUM_REQ sources: fill, drain, flush per grant.
// state | meaning: IDLE arbitrate | FILL accept burst | DRAIN read encoder out | FLUSH reset encoder
module rle_share_ctrl
    import rle_share_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = ENC_DATA_W,
    parameter int DEPTH     = ENC_DEPTH,
    parameter int BURST_MAX = 8,
    parameter int STALL_MAX = 16,
    parameter int ID_W      = 2
) (
    input  logic                      data_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      drain_ready,
    output logic [DATA_W-1:0]         enc_data_in,
    output logic                      enc_data_in_valid,
    output logic                      enc_write_signal,
    output logic                      enc_read_signal,
    output logic                      enc_reset,
    output logic [ID_W-1:0]           active_id,
    output logic                      busy
);

    localparam int BEAT_W  = $clog2(BURST_MAX + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]         occ_q, occ_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [ID_W-1:0]    pick_grant;
    logic               pick_any;
    logic               fill_ready;
    logic               xfer;
    logic [DATA_W-1:0]  src_data [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_src
        assign src_data[g] = req_data[g*DATA_W +: DATA_W];
    end

    rle_share_ctrl_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_grant),
        .any_valid_o (pick_any)
    );

    always_ff @(posedge data_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            occ_q    <= '0;
            beat_q   <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            occ_q    <= occ_d;
            beat_q   <= beat_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        rr_ptr_d          = rr_ptr_q;
        occ_d             = occ_q;
        beat_d            = beat_q;
        stall_d           = stall_q;
        req_ready         = '0;
        enc_data_in       = '0;
        enc_data_in_valid = 1'b0;
        enc_write_signal  = 1'b0;
        enc_read_signal   = 1'b0;
        enc_reset         = 1'b0;
        fill_ready        = 1'b0;
        xfer              = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                fill_ready         = (occ_q < 8'(DEPTH));
                req_ready[grant_q] = fill_ready;
                xfer               = fill_ready && req_valid[grant_q];
                if (xfer) begin
                    enc_write_signal  = 1'b1;
                    enc_data_in_valid = 1'b1;
                    enc_data_in       = src_data[grant_q];
                    occ_d             = occ_q + 8'd1;
                    beat_d            = beat_q + 1'b1;
                    stall_d           = '0;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
                // Exit tests use the post-cycle counts so the burst closes on the limiting cycle.
                if ((xfer && req_last[grant_q]) || (beat_d == BEAT_W'(BURST_MAX)) ||
                    (occ_d == 8'(DEPTH)) || (stall_d == STALL_W'(STALL_MAX))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (occ_q == 8'd0) begin
                    state_d = ST_FLUSH;
                end else if (drain_ready) begin
                    enc_read_signal = 1'b1;
                    occ_d           = occ_q - 8'd1;
                end
            end
            ST_FLUSH: begin
                enc_reset = 1'b1;
                rr_ptr_d  = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A reset cycle must not leak a strobe from the state being aborted.
        if (reset) begin
            req_ready         = '0;
            enc_data_in       = '0;
            enc_data_in_valid = 1'b0;
            enc_write_signal  = 1'b0;
            enc_read_signal   = 1'b0;
            enc_reset         = 1'b1;
        end
    end

    assign active_id = reset ? '0 : grant_q;
    assign busy      = !reset && (state_q != ST_IDLE);

endmodule

// File: tb/tb_rle_share_ctrl.sv
// Bench for rle_share_ctrl: directed scenarios plus random traffic against a burst-level model.
module tb_rle_share_ctrl;

    localparam int N  = 4;
    localparam int DW = 5;
    localparam int BM = 8;
    localparam int SM = 16;

    logic            data_clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            drain_ready;
    logic [DW-1:0]   enc_data_in;
    logic            enc_data_in_valid, enc_write_signal, enc_read_signal, enc_reset;
    logic [1:0]      active_id;
    logic            busy;

    rle_share_ctrl dut (
        .data_clk          (data_clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .drain_ready       (drain_ready),
        .enc_data_in       (enc_data_in),
        .enc_data_in_valid (enc_data_in_valid),
        .enc_write_signal  (enc_write_signal),
        .enc_read_signal   (enc_read_signal),
        .enc_reset         (enc_reset),
        .active_id         (active_id),
        .busy              (busy)
    );

    always #5 data_clk = ~data_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Source side: each source presents the head of its own packet queue.
    logic [DW-1:0] sq [N][$];
    bit            lq [N][$];
    bit            en [N];
    bit            rnd_mode, dr_rand, dr_val, rst_drv;

    // Burst-level model: what the arbiter should pick and how long each burst lives.
    bit         in_burst, closed, prev_idle;
    logic [N-1:0] prev_valid;
    int         cur, beats, reads, idle_cnt, settle, exp_rr;
    int         obs_wr, obs_rd, obs_fl;
    int         glog[$];
    int         blen[$];

    function automatic int rr_model(input int start, input logic [N-1:0] vec);
        for (int k = 0; k < N; k++) begin
            if (vec[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0) begin
                req_valid[i]          = en[i] && (!rnd_mode || ($urandom_range(0, 9) < 8));
                req_data[i*DW +: DW]  = sq[i][0];
                req_last[i]           = lq[i][0];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = DW'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
        drain_ready = dr_rand ? 1'($urandom) : dr_val;
        reset       = rst_drv;
    endtask

    task automatic monitor();
        bit idle_now, exp_wr, exp_rd, was_last;
        if (reset) begin
            chk("rst_enc_reset", enc_reset, 1);
            chk("rst_ready", req_ready, 0);
            chk("rst_wr", enc_write_signal, 0);
            chk("rst_rd", enc_read_signal, 0);
            chk("rst_busy", busy, 0);
            in_burst  = 0;
            closed    = 0;
            exp_rr    = 0;
            prev_idle = 0;
            return;
        end
        if (enc_write_signal) obs_wr++;
        if (enc_read_signal)  obs_rd++;
        if (enc_reset)        obs_fl++;
        chk("wr_rd_excl", enc_write_signal && enc_read_signal, 0);
        if (!in_burst && prev_idle && prev_valid != 0) begin
            in_burst = 1; closed = 0; beats = 0; reads = 0; idle_cnt = 0; settle = 0;
            cur = rr_model(exp_rr, prev_valid);
            glog.push_back(int'(active_id));
        end
        idle_now = !in_burst;
        if (!in_burst) begin
            chk("idle_busy", busy, 0);
            chk("idle_ready", req_ready, 0);
            chk("idle_wr", enc_write_signal, 0);
            chk("idle_rd", enc_read_signal, 0);
            chk("idle_enc_reset", enc_reset, 0);
        end else begin
            chk("busy", busy, 1);
            chk("active_id", active_id, cur);
            if (!closed) begin
                exp_wr = req_valid[cur];
                chk("ready", req_ready, 1 << cur);
                chk("wr", enc_write_signal, exp_wr);
                chk("rd_fill", enc_read_signal, 0);
                chk("enc_reset_fill", enc_reset, 0);
                if (exp_wr && sq[cur].size() > 0) begin
                    chk("data", enc_data_in, sq[cur][0]);
                    chk("data_valid", enc_data_in_valid, 1);
                    was_last = lq[cur][0];
                    void'(sq[cur].pop_front());
                    void'(lq[cur].pop_front());
                    beats++;
                    idle_cnt = 0;
                    if (was_last || beats == BM) closed = 1;
                end else begin
                    chk("data_valid_idle", enc_data_in_valid, 0);
                    idle_cnt++;
                    if (idle_cnt == SM) closed = 1;
                end
                if (closed) blen.push_back(beats);
            end else begin
                exp_rd = drain_ready && (reads < beats);
                chk("ready_drain", req_ready, 0);
                chk("wr_drain", enc_write_signal, 0);
                chk("rd", enc_read_signal, exp_rd);
                chk("flush", enc_reset, settle == 2);
                if (exp_rd) reads++;
                if (settle == 2) begin
                    exp_rr   = (cur + 1) % N;
                    in_burst = 0;
                end
            end
            if (in_burst && closed && reads == beats) settle++;
        end
        prev_idle  = idle_now;
        prev_valid = req_valid;
    endtask

    task automatic step();
        drive();
        @(negedge data_clk);
        monitor();
        @(posedge data_clk);
        #1;
    endtask

    task automatic run_until_flush(input string tag, input int target, input int budget);
        int n = 0;
        while (obs_fl < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, obs_fl >= target, 1);
    endtask

    task automatic push_pkt(input int src, input int len, input bit with_last);
        for (int j = 0; j < len; j++) begin
            sq[src].push_back(DW'($urandom_range(0, 31)));
            lq[src].push_back(with_last && (j == len - 1));
        end
    endtask

    task automatic all_en(input bit v);
        for (int i = 0; i < N; i++) en[i] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, f0, g0, b0, n;
        int exp_g2 [5] = '{0, 1, 2, 3, 0};
        int exp_g3 [4] = '{3, 0, 1, 2};
        rnd_mode = 0; dr_rand = 0; dr_val = 1; rst_drv = 1;
        all_en(0);
        obs_wr = 0; obs_rd = 0; obs_fl = 0; exp_rr = 0; prev_idle = 0; prev_valid = '0;
        drive();
        @(posedge data_clk); #1;
        repeat (3) step();
        rst_drv = 0;
        step();

        // All four sources streaming with no last: full 8-beat bursts in rotation.
        for (int i = 0; i < N; i++) push_pkt(i, 48, 0);
        all_en(1);
        g0 = glog.size(); b0 = blen.size();
        run_until_flush("t2_timeout", obs_fl + 5, 400);
        all_en(0);
        for (int k = 0; k < 5; k++) begin
            chk("t2_grant", glog[g0 + k], exp_g2[k]);
            chk("t2_burst_len", blen[b0 + k], BM);
        end
        for (int i = 0; i < N; i++) begin sq[i].delete(); lq[i].delete(); end
        step();

        // Source 0: 5,5,9 with last on the third.
        sq[0].push_back(5'd5); lq[0].push_back(0);
        sq[0].push_back(5'd5); lq[0].push_back(0);
        sq[0].push_back(5'd9); lq[0].push_back(1);
        en[0] = 1;
        w0 = obs_wr; r0 = obs_rd; f0 = obs_fl;
        run_until_flush("t1_timeout", f0 + 1, 100);
        chk("t1_writes", obs_wr - w0, 3);
        chk("t1_reads", obs_rd - r0, 3);
        chk("t1_flushes", obs_fl - f0, 1);
        step();
        chk("t1_busy_after", busy, 0);
        // rr_ptr is now 1: with 0 and 1 both requesting, 1 must win.
        push_pkt(0, 1, 1); push_pkt(1, 1, 1);
        en[1] = 1;
        g0 = glog.size();
        run_until_flush("t1_rr_timeout", obs_fl + 2, 100);
        chk("t1_rr_first", glog[g0], 1);
        chk("t1_rr_second", glog[g0 + 1], 0);
        all_en(0);

        // Source 2 sends one symbol then goes quiet: stall timeout closes the burst.
        push_pkt(2, 1, 0);
        en[2] = 1;
        w0 = obs_wr; r0 = obs_rd; b0 = blen.size(); g0 = glog.size();
        run_until_flush("t3_timeout", obs_fl + 1, 100);
        chk("t3_grant", glog[g0], 2);
        chk("t3_writes", obs_wr - w0, 1);
        chk("t3_reads", obs_rd - r0, 1);
        chk("t3_burst_len", blen[b0], 1);
        for (int i = 0; i < N; i++) push_pkt(i, 1, 1);
        all_en(1);
        g0 = glog.size();
        run_until_flush("t3_rr_timeout", obs_fl + 4, 200);
        for (int k = 0; k < 4; k++) chk("t3_rr_order", glog[g0 + k], exp_g3[k]);
        all_en(0);

        // Downstream stalls for 10 cycles in DRAIN.
        dr_val = 0;
        push_pkt(1, 4, 1);
        en[1] = 1;
        n = 0;
        while (!(in_burst && closed) && n < 50) begin step(); n++; end
        chk("t4_closed", in_burst && closed, 1);
        r0 = obs_rd;
        repeat (10) step();
        chk("t4_no_reads", obs_rd - r0, 0);
        chk("t4_busy_held", busy, 1);
        dr_val = 1;
        step();
        chk("t4_read_resume", obs_rd - r0, 1);
        run_until_flush("t4_timeout", obs_fl + 1, 50);
        chk("t4_reads_total", obs_rd - r0, 4);
        all_en(0);

        // Reset in the middle of a FILL after 4 beats.
        push_pkt(1, 10, 0);
        en[1] = 1;
        w0 = obs_wr; n = 0;
        while (obs_wr - w0 < 4 && n < 50) begin step(); n++; end
        chk("t5_four_beats", obs_wr - w0, 4);
        rst_drv = 1; en[1] = 0;
        sq[1].delete(); lq[1].delete();
        step();
        rst_drv = 0;
        step();
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_ready_after_rst", req_ready, 0);
        push_pkt(0, 2, 1); push_pkt(3, 1, 1);
        en[0] = 1; en[3] = 1;
        g0 = glog.size(); r0 = obs_rd;
        run_until_flush("t5_timeout", obs_fl + 2, 100);
        chk("t5_rr_reset_first", glog[g0], 0);
        chk("t5_rr_reset_second", glog[g0 + 1], 3);
        chk("t5_reads_clean", obs_rd - r0, 3);
        all_en(0);

        // Random traffic, random downstream backpressure, occasional resets.
        rnd_mode = 1; dr_rand = 1;
        all_en(1);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (sq[i].size() == 0 && $urandom_range(0, 3) == 0)
                    push_pkt(i, $urandom_range(1, 12), 1'($urandom_range(0, 3) != 0));
                if ($urandom_range(0, 59) == 0) en[i] = !en[i];
            end
            rst_drv = ($urandom_range(0, 499) == 0);
            step();
        end
        rst_drv = 0;
        all_en(0);
        dr_val = 1; dr_rand = 0;
        n = 0;
        while (in_burst && n < 200) begin step(); n++; end
        chk("final_idle", in_burst, 0);
        chk("final_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
